// File: rtl/store_write_buffer_pkg.sv
// Shared constants and the entry record for the store write buffer.
// Ports: none (package mips_mem_pkg).
package mips_mem_pkg;

  localparam int WB_DEPTH_DEFAULT = 4;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int WORD_LSB         = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/store_write_buffer_if.sv
// Memory-side req/ack bus of the store write buffer.
// master: mem_req/mem_addr/mem_wdata out, mem_ack in; slave mirrors it.
interface store_write_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );

endinterface

// File: rtl/wb_fifo_ctrl.sv
// Pointer/occupancy control for the store write buffer FIFO.
// In: clk, reset, push_req, pop_req. Out: push, pop, head, tail, count, full, empty.
module wb_fifo_ctrl #(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_req,
  input  logic          pop_req,
  output logic          push,
  output logic          pop,
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A full buffer drops the store (core is stalled and re-presents it);
  // an ack with nothing requested is ignored.
  assign push = push_req && !full;
  assign pop  = pop_req && !empty;

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer between the core data port and a slow data memory.
// In: CLK, reset, memWrite, Addressmem, WriteDataMem, lookup_addr.
// Out: stall, fwd_hit, fwd_data, count; mem (master): mem_req/addr/wdata, mem_ack in.
// Option: define STORE_FWD_EN to enable store-to-load forwarding.
module store_write_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT,
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     memWrite,
  input  logic [AW-1:0]            Addressmem,
  input  logic [DW-1:0]            WriteDataMem,
  output logic                     stall,
  input  logic [AW-1:0]            lookup_addr,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic [$clog2(DEPTH):0]   count,
  store_write_buffer_if.master     mem
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t            ent_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic              push;
  logic              pop;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              full;
  logic              empty;

  wb_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_ctrl (
    .clk      (CLK),
    .reset    (reset),
    .push_req (memWrite),
    .pop_req  (mem.mem_ack),
    .push     (push),
    .pop      (pop),
    .head     (head),
    .tail     (tail),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Payload needs no reset; it is only observed through valid/empty.
  always_ff @(posedge CLK) begin
    if (push) ent_q[tail] <= '{addr: Addressmem, data: WriteDataMem};
  end

  // push and pop never hit the same slot: push needs !full, pop needs !empty.
  always_ff @(posedge CLK) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (pop)  valid_q[head] <= 1'b0;
      if (push) valid_q[tail] <= 1'b1;
    end
  end

  assign stall         = full;
  assign mem.mem_req   = !empty;
  assign mem.mem_addr  = empty ? '0 : ent_q[head].addr;
  assign mem.mem_wdata = empty ? '0 : ent_q[head].data;

`ifdef STORE_FWD_EN
  logic [PW-1:0] idx;
  logic          unused_lsb;

  assign unused_lsb = ^lookup_addr[WORD_LSB-1:0];

  // Walk oldest to newest so the youngest match overwrites older ones.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid_q[idx] &&
          ent_q[idx].addr[AW-1:WORD_LSB] == lookup_addr[AW-1:WORD_LSB]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_q[idx].data;
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{lookup_addr, valid_q};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
// Randomized scoreboard bench for store_write_buffer.
// Drives the core and memory sides; reference model is a queue of stores.
module tb_store_write_buffer;
  import mips_mem_pkg::*;

  localparam int DEPTH = WB_DEPTH_DEFAULT;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          reset;
  logic          memWrite;
  logic [31:0]   Addressmem;
  logic [31:0]   WriteDataMem;
  logic          stall;
  logic [31:0]   lookup_addr;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [CW-1:0] count;

  store_write_buffer_if #(.AW(32), .DW(32)) mem_bus ();

  store_write_buffer #(
    .DEPTH (DEPTH),
    .AW    (32),
    .DW    (32)
  ) dut (
    .CLK          (CLK),
    .reset        (reset),
    .memWrite     (memWrite),
    .Addressmem   (Addressmem),
    .WriteDataMem (WriteDataMem),
    .stall        (stall),
    .lookup_addr  (lookup_addr),
    .fwd_hit      (fwd_hit),
    .fwd_data     (fwd_data),
    .count        (count),
    .mem          (mem_bus.master)
  );

  always #5 CLK = ~CLK;

  int        n_cmp = 0;
  int        n_bad = 0;
  bit        checking = 1'b0;
  wb_entry_t mq[$];
  wb_entry_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of buffer contents: what is accepted this edge and what drains.
  always @(posedge CLK) begin
    bit do_push;
    bit do_pop;
    if (reset === 1'b1) begin
      mq.delete();
      exp_q.delete();
    end else begin
      do_push = (memWrite === 1'b1) && (mq.size() < DEPTH);
      do_pop  = (mem_bus.mem_ack === 1'b1) && (mq.size() > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{addr: Addressmem, data: WriteDataMem});
        exp_q.push_back('{addr: Addressmem, data: WriteDataMem});
      end
    end
  end

  // Monitor: state outputs every cycle, drained entries on each handshake.
  always @(negedge CLK) begin
    logic        e_hit;
    logic [31:0] e_data;
    wb_entry_t   e;
    if (checking) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("stall", 32'(stall), 32'(mq.size() == DEPTH));
      chk("mem_req", 32'(mem_bus.mem_req), 32'(mq.size() != 0));
      chk("mem_addr", mem_bus.mem_addr,
          mq.size() != 0 ? mq[0].addr : 32'h0);
      chk("mem_wdata", mem_bus.mem_wdata,
          mq.size() != 0 ? mq[0].data : 32'h0);
      e_hit  = 1'b0;
      e_data = 32'h0;
`ifdef STORE_FWD_EN
      foreach (mq[i])
        if (mq[i].addr[31:2] == lookup_addr[31:2]) begin
          e_hit  = 1'b1;
          e_data = mq[i].data;
        end
`endif
      chk("fwd_hit", 32'(fwd_hit), 32'(e_hit));
      chk("fwd_data", fwd_data, e_data);
      if (mem_bus.mem_req === 1'b1 && mem_bus.mem_ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL drain_extra: got %h expected no request",
                   mem_bus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("drain_addr", mem_bus.mem_addr, e.addr);
          chk("drain_data", mem_bus.mem_wdata, e.data);
        end
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic ack,
                       input logic [31:0] look, input logic rst = 1'b0);
    reset           = rst;
    memWrite        = we;
    Addressmem      = a;
    WriteDataMem    = d;
    mem_bus.mem_ack = ack;
    lookup_addr     = look;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n, input logic ack = 1'b0);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 32'h0, ack, 32'h0);
  endtask

  initial begin
    reset           = 1'b1;
    memWrite        = 1'b0;
    Addressmem      = '0;
    WriteDataMem    = '0;
    mem_bus.mem_ack = 1'b0;
    lookup_addr     = '0;
    @(posedge CLK);
    #1;
    checking = 1'b1;
    idle(5);

    // single store, then drain
    drive(1'b1, 32'h54, 32'hAB, 1'b0, 32'h0);
    idle(1);
    idle(1, 1'b1);
    idle(2);

    // fill, stall, pop-while-full, held store accepted
    drive(1'b1, 32'h10, 32'h100, 1'b0, 32'h0);
    drive(1'b1, 32'h14, 32'h101, 1'b0, 32'h0);
    drive(1'b1, 32'h18, 32'h102, 1'b0, 32'h0);
    drive(1'b1, 32'h1C, 32'h103, 1'b0, 32'h0);
    drive(1'b1, 32'h20, 32'h104, 1'b0, 32'h0);
    drive(1'b1, 32'h20, 32'h104, 1'b1, 32'h0);
    drive(1'b1, 32'h20, 32'h104, 1'b0, 32'h0);
    idle(6, 1'b1);

    // simultaneous push/pop at count 2
    drive(1'b1, 32'h30, 32'h200, 1'b0, 32'h0);
    drive(1'b1, 32'h34, 32'h201, 1'b0, 32'h0);
    drive(1'b1, 32'h38, 32'h202, 1'b1, 32'h0);
    idle(1);
    idle(3, 1'b1);

    // forwarding: newest match wins, word granularity
    drive(1'b1, 32'h40, 32'h11, 1'b0, 32'h0);
    drive(1'b1, 32'h40, 32'h22, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h43);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h44);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h41);
    idle(2, 1'b1);

    // reset mid-drain, later store drains alone
    drive(1'b1, 32'h60, 32'h300, 1'b0, 32'h0);
    drive(1'b1, 32'h64, 32'h301, 1'b0, 32'h0);
    drive(1'b1, 32'h68, 32'h302, 1'b0, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b1);
    idle(2);
    drive(1'b1, 32'h80, 32'h400, 1'b0, 32'h0);
    idle(3, 1'b1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 99) < 55),
            32'h40 + 32'($urandom_range(0, 31)),
            $urandom,
            1'($urandom_range(0, 99) < 40),
            32'h40 + 32'($urandom_range(0, 31)),
            1'($urandom_range(0, 249) == 0));
    end

    idle(DEPTH + 4, 1'b1);
    chk("final_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
